// File: rtl/ir_receiver_sm_if.sv
// Decoded-command side of the IR car receiver: command word plus outcome strobes.
// The receiver drives it through master; a consumer watches through slave.
interface ir_receiver_sm_if;
    logic [3:0] COMMAND;
    logic       PACKET_VALID;
    logic       PACKET_ERROR;
    logic       BUSY;

    modport master (
        output COMMAND,
        output PACKET_VALID,
        output PACKET_ERROR,
        output BUSY
    );

    modport slave (
        input COMMAND,
        input PACKET_VALID,
        input PACKET_ERROR,
        input BUSY
    );
endinterface

// File: rtl/ir_receiver_sm.sv
// IR car packet receiver: recovers the burst envelope from the raw 36 kHz carrier,
// counts pulses per burst and decodes Start/CarSelect/R/L/B/F into a 4-bit command.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// ST_IDLE        | no packet in flight; waiting for a Start-length burst
// ST_WAIT_CARSEL | Start accepted; next burst must be a CarSelect
// ST_WAIT_DIR    | collecting direction fields R,L,B,F (field_idx 0..3)
module ir_receiver_sm #(
    parameter int CLK_FREQ         = 100_000_000,
    parameter int CARRIER_FREQ     = 36_000,
    parameter int ENV_HOLD_PERIODS = 2,
    parameter int MIN_BURST        = 10,
    parameter int START_MIN        = 160,
    parameter int CARSEL_MIN       = 35,
    parameter int CARSEL_MAX       = 60,
    parameter int ASSERT_THRESH    = 35,
    parameter int GAP_MAX_PERIODS  = 40
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              IR_IN,
    ir_receiver_sm_if.master  bus
);

    localparam int PERIOD_CYC   = CLK_FREQ / CARRIER_FREQ;
    localparam int ENV_HOLD_CYC = ENV_HOLD_PERIODS * PERIOD_CYC;
    localparam int GAP_CYC      = GAP_MAX_PERIODS * PERIOD_CYC;
    localparam int SIL_W        = $clog2(GAP_CYC + 1);

    localparam logic [SIL_W-1:0] SIL_MAX = '1;
    localparam logic [SIL_W-1:0] HOLD_TC = SIL_W'(ENV_HOLD_CYC - 1);
    localparam logic [SIL_W-1:0] GAP_TC  = SIL_W'(GAP_CYC - 1);

    localparam logic [7:0] MIN_BURST_C  = 8'(MIN_BURST);
    localparam logic [7:0] START_MIN_C  = 8'(START_MIN);
    localparam logic [7:0] CARSEL_MIN_C = 8'(CARSEL_MIN);
    localparam logic [7:0] CARSEL_MAX_C = 8'(CARSEL_MAX);
    localparam logic [7:0] THRESH_C     = 8'(ASSERT_THRESH);

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_WAIT_CARSEL = 2'd1;
    localparam logic [1:0] ST_WAIT_DIR    = 2'd2;

    logic             ir_meta;
    logic             ir_sync;
    logic             ir_prev;
    logic             edge_p;

    logic             env;
    logic [7:0]       pulse_cnt;
    logic [SIL_W-1:0] silence_cnt;
    logic             burst_end;
    logic             gap_expired;

    logic [1:0]       state;
    logic [1:0]       field_idx;
    logic [3:0]       shadow;
    logic [3:0]       shadow_next;
    logic             dir_bit;
    logic [3:0]       command;
    logic             packet_valid;
    logic             packet_error;
    logic             busy;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ir_meta <= 1'b0;
            ir_sync <= 1'b0;
            ir_prev <= 1'b0;
            edge_p  <= 1'b0;
        end else begin
            ir_meta <= IR_IN;
            ir_sync <= ir_meta;
            ir_prev <= ir_sync;
            edge_p  <= ir_sync & ~ir_prev;
        end
    end

    // Burst ends on the cycle silence_cnt steps onto the hold count; an edge
    // arriving on that same cycle keeps the burst alive.
    assign burst_end   = env && !edge_p && (silence_cnt == HOLD_TC);
    assign gap_expired = (state != ST_IDLE) && !env && !edge_p && (silence_cnt == GAP_TC);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            env         <= 1'b0;
            pulse_cnt   <= 8'd0;
            silence_cnt <= '0;
        end else if (edge_p) begin
            env         <= 1'b1;
            silence_cnt <= '0;
            if (pulse_cnt != 8'hFF) begin
                pulse_cnt <= pulse_cnt + 8'd1;
            end
        end else begin
            if (silence_cnt != SIL_MAX) begin
                silence_cnt <= silence_cnt + 1'b1;
            end
            if (burst_end) begin
                env       <= 1'b0;
                pulse_cnt <= 8'd0;
            end
        end
    end

    assign dir_bit = (pulse_cnt >= THRESH_C);

    always_comb begin
        shadow_next = shadow;
        shadow_next[2'd3 - field_idx] = dir_bit;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state        <= ST_IDLE;
            field_idx    <= 2'd0;
            shadow       <= 4'd0;
            command      <= 4'd0;
            packet_valid <= 1'b0;
            packet_error <= 1'b0;
            busy         <= 1'b0;
        end else begin
            packet_valid <= 1'b0;
            packet_error <= 1'b0;
            if (burst_end) begin
                case (state)
                    ST_IDLE: begin
                        if (pulse_cnt >= START_MIN_C) begin
                            state <= ST_WAIT_CARSEL;
                            busy  <= 1'b1;
                        end
                    end
                    ST_WAIT_CARSEL: begin
                        if ((pulse_cnt >= CARSEL_MIN_C) && (pulse_cnt <= CARSEL_MAX_C)) begin
                            state     <= ST_WAIT_DIR;
                            field_idx <= 2'd0;
                        end else begin
                            state        <= ST_IDLE;
                            packet_error <= 1'b1;
                            busy         <= 1'b0;
                        end
                    end
                    ST_WAIT_DIR: begin
                        if (pulse_cnt < MIN_BURST_C) begin
                            state        <= ST_IDLE;
                            packet_error <= 1'b1;
                            busy         <= 1'b0;
                        end else begin
                            shadow <= shadow_next;
                            if (field_idx == 2'd3) begin
                                command      <= shadow_next;
                                packet_valid <= 1'b1;
                                state        <= ST_IDLE;
                                busy         <= 1'b0;
                            end else begin
                                field_idx <= field_idx + 2'd1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (gap_expired) begin
                state        <= ST_IDLE;
                packet_error <= 1'b1;
                busy         <= 1'b0;
            end
        end
    end

    assign bus.COMMAND      = command;
    assign bus.PACKET_VALID = packet_valid;
    assign bus.PACKET_ERROR = packet_error;
    assign bus.BUSY         = busy;

endmodule

// File: doc/ir_receiver_sm.md
Name: ir_receiver_sm

Overview:
- Decodes the pulse-width-coded IR car packet sent by the team's IR transmitter: Start burst, CarSelect burst, then Right/Left/Backward/Forward bursts, separated by gaps.
- Input is the raw 36 kHz modulated carrier, either looped back from the transmitter or taken from a photodiode front end.
- Recovers the burst envelope, counts carrier pulses per burst, classifies each burst and validates the packet.
- Presents the 4-bit command to the bus side with a one-cycle valid strobe. Malformed packets produce an error strobe instead.

Parameters:
- CLK_FREQ, 100_000_000, system clock in Hz.
- CARRIER_FREQ, 36_000, carrier in Hz. PERIOD_CYC = CLK_FREQ/CARRIER_FREQ (integer division, 2777).
- ENV_HOLD_PERIODS, 2, carrier periods with no rising edge before the envelope is declared off. ENV_HOLD_CYC = ENV_HOLD_PERIODS*PERIOD_CYC.
- MIN_BURST, 10, pulse counts below this are noise.
- START_MIN, 160, minimum pulse count for a Start burst.
- CARSEL_MIN, 35, CarSelect lower bound, inclusive.
- CARSEL_MAX, 60, CarSelect upper bound, inclusive.
- ASSERT_THRESH, 35, direction burst count at or above this decodes as 1; MIN_BURST..ASSERT_THRESH-1 decodes as 0.
- GAP_MAX_PERIODS, 40, maximum silence between bursts inside a packet.

Ports:
- CLK  input  1  system clock.
- RESETN  input  1  reset; asynchronous, active-low.
- IR_IN  input  1  raw modulated IR carrier, asynchronous to CLK.
- COMMAND  output  4  last valid command: [3] right, [2] left, [1] back, [0] forward.
- PACKET_VALID  output  1  one-cycle strobe; COMMAND updated this cycle.
- PACKET_ERROR  output  1  one-cycle strobe; packet aborted.
- BUSY  output  1  high from Start-burst acceptance until VALID/ERROR.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0. Reset mid-packet discards the partial packet with no strobe.
- Input path: 2-flop synchronizer on IR_IN, then registered rising-edge detect (edge_p).
- Envelope:
  - edge_p sets env=1, increments pulse_cnt (8-bit, saturates at 255) and clears silence_cnt.
  - Otherwise silence_cnt increments (saturating).
  - When silence_cnt reaches ENV_HOLD_CYC with env=1: env clears and burst_end pulses for 1 cycle carrying the pulse_cnt value.
  - pulse_cnt clears on the cycle after burst_end.
  - edge_p and the hold expiry in the same cycle: the edge wins and the burst continues.
- FSM states: IDLE, WAIT_CARSEL, WAIT_DIR (field index 0..3 = R,L,B,F). Each burst is classified at its burst_end.
  - IDLE:
    - burst with count >= START_MIN goes to WAIT_CARSEL and sets BUSY.
    - any other burst is ignored silently.
  - WAIT_CARSEL:
    - count in CARSEL_MIN..CARSEL_MAX goes to WAIT_DIR, index 0.
    - otherwise ERROR.
  - WAIT_DIR:
    - count < MIN_BURST gives ERROR.
    - otherwise store bit = (count >= ASSERT_THRESH) into shadow[3-index], then index+1.
    - after index 3: COMMAND <= shadow, PACKET_VALID=1, go to IDLE, BUSY=0.
  - Gap timeout: in any non-IDLE state with env=0, silence_cnt reaching GAP_MAX_PERIODS*PERIOD_CYC gives ERROR.
  - ERROR: PACKET_ERROR=1 for 1 cycle, go to IDLE, BUSY=0, COMMAND unchanged.
- Latency: PACKET_VALID asserts ENV_HOLD_CYC+4 cycles (±1 allowed) after the last rising edge of IR_IN in the Forward burst. No trailing gap is required.
- Back-to-back packets: the next Start is accepted immediately from IDLE.
- PACKET_VALID and PACKET_ERROR are never high together.
- Counter widths: silence_cnt must hold GAP_MAX_PERIODS*PERIOD_CYC (≥17 bits at defaults).

Test Plan:
- Transmitter-format packet at defaults, command 4'b1010 (bursts 191/47/47/22/47/22, gaps 25 periods) -> one PACKET_VALID, COMMAND=4'b1010, BUSY high from Start end to VALID, no PACKET_ERROR.
- Two consecutive packets, 4'b0001 then 4'b1111 -> two VALID strobes; COMMAND=0001, then 1111.
- Start 191, CarSelect 20 pulses -> PACKET_ERROR at CarSelect burst end; COMMAND keeps its prior value; next good packet decodes.
- Start and CarSelect, then 60 periods of silence -> PACKET_ERROR exactly at 40*2777 cycles of silence after the CarSelect last edge.
- Lone 8-pulse and 100-pulse bursts in IDLE -> no strobes, BUSY stays 0. Packet with Forward burst of 5 pulses -> PACKET_ERROR.
- RESETN low during the Left burst, then released -> all outputs 0, no strobe; following full packet 4'b0100 decodes correctly.
